// File: rtl/mmio_gpio_hub.sv
// Memory-mapped GPIO slave: LED register, debounced switches with sticky change flags, registered reads.
// Optional 32-bit free-running timer at offset 0x80 when IO_TIMER_EN is defined.
module mmio_gpio_hub #(
  parameter int SW_WIDTH  = 24,
  parameter int LED_WIDTH = 24,
  parameter int DB_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [SW_WIDTH-1:0]  sw_db
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [7:0] OFF_LED   = 8'h60;
  localparam logic [7:0] OFF_SW    = 8'h70;
  localparam logic [7:0] OFF_CHG   = 8'h74;
  localparam logic [7:0] OFF_TIMER = 8'h80;

  logic                in_region;
  logic [7:0]          offset;
  logic                rd_hit;
  logic                wr_hit;
  logic                chg_clr;
  logic [31:0]         rd_mux;
  logic [SW_WIDTH-1:0] s1;
  logic [SW_WIDTH-1:0] s2;
  logic [SW_WIDTH-1:0] chg;
  logic [SW_WIDTH-1:0] accept;
  logic [CW-1:0]       cnt [SW_WIDTH];
  logic                unused_bits;

  assign in_region   = (addr[31:10] == 22'h3FFFFF);
  assign offset      = addr[7:0];
  assign wr_hit      = io_write && in_region;
  // A simultaneous write suppresses the read entirely
  assign rd_hit      = io_read && !io_write && in_region;
  assign chg_clr     = rd_hit && (offset == OFF_CHG);
  assign unused_bits = ^{addr[9:8], wdata};

`ifdef IO_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (wr_hit && offset == OFF_TIMER)
      timer <= wdata;
    else
      timer <= timer + 32'd1;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_LED:   rd_mux[LED_WIDTH-1:0] = led_out;
      OFF_SW:    rd_mux[SW_WIDTH-1:0]  = sw_db;
      OFF_CHG:   rd_mux[SW_WIDTH-1:0]  = chg;
`ifdef IO_TIMER_EN
      OFF_TIMER: rd_mux = timer;
`endif
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      led_out <= '0;
    else if (wr_hit && offset == OFF_LED)
      led_out <= wdata[LED_WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_hit;
      if (rd_hit)
        rdata <= rd_mux;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < SW_WIDTH; i++)
      accept[i] = (s2[i] != sw_db[i]) && (cnt[i] == CNT_LAST);
  end

  // Counter restarts whenever the synchronised input matches the accepted state or an accept fires
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SW_WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (s2[i] == sw_db[i] || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // New accepts win over a same-cycle clear-on-read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_db <= '0;
      chg   <= '0;
    end else begin
      sw_db <= sw_db ^ accept;
      chg   <= (chg & ~{SW_WIDTH{chg_clr}}) | accept;
    end
  end

endmodule

// File: tb/tb_mmio_gpio_hub.sv
// Scoreboard bench for mmio_gpio_hub: directed scenarios plus randomized bus/switch traffic
// checked against a history-window reference model.
module tb_mmio_gpio_hub;

  localparam int SW  = 24;
  localparam int LED = 24;
  localparam int DB  = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic           io_read;
  logic           io_write;
  logic [31:0]    addr;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic           rvalid;
  logic [SW-1:0]  sw_in;
  logic [LED-1:0] led_out;
  logic [SW-1:0]  sw_db;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0]    exp_q[$];
  logic [LED-1:0] m_led;
  logic [SW-1:0]  m_db;
  logic [SW-1:0]  m_chg;
  logic [SW-1:0]  hist[$];
  int unsigned    cyc = 0;
`ifdef IO_TIMER_EN
  logic [31:0]    tbase;
  int unsigned    tcyc;
`endif

  mmio_gpio_hub #(.SW_WIDTH(SW), .LED_WIDTH(LED), .DB_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .sw_in(sw_in), .led_out(led_out), .sw_db(sw_db)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Reference model: a switch bit flips once the last DB synchronised samples
  // (raw input delayed two edges) all disagree with the accepted value.
  always @(posedge clock or posedge reset) begin : model
    logic        region;
    logic [7:0]  off;
    logic [31:0] r;
    logic        rd;
    logic [SW-1:0] set;
    logic        all_diff;
    if (reset) begin
      m_led = '0;
      m_db  = '0;
      m_chg = '0;
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back('0);
      exp_q.delete();
`ifdef IO_TIMER_EN
      tbase = '0;
      tcyc  = cyc;
`endif
    end else begin
      region = (addr[31:10] == 22'h3FFFFF);
      off    = addr[7:0];
      rd     = io_read && !io_write && region;
      if (rd) begin
        r = '0;
        case (off)
          8'h60: r = 32'(m_led);
          8'h70: r = 32'(m_db);
          8'h74: r = 32'(m_chg);
`ifdef IO_TIMER_EN
          8'h80: r = tbase + 32'(cyc - tcyc);
`endif
          default: r = '0;
        endcase
        exp_q.push_back(r);
      end
      cyc++;
      if (io_write && region) begin
        if (off == 8'h60) m_led = wdata[LED-1:0];
`ifdef IO_TIMER_EN
        if (off == 8'h80) begin
          tbase = wdata;
          tcyc  = cyc;
        end
`endif
      end
      hist.push_back(sw_in);
      void'(hist.pop_front());
      set = '0;
      for (int i = 0; i < SW; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (hist[j][i] == m_db[i]) all_diff = 1'b0;
        set[i] = all_diff;
      end
      if (rd && off == 8'h74) m_chg = '0;
      m_chg = m_chg | set;
      m_db  = m_db ^ set;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_rvalid: got rvalid=1 rdata=%h, expected no read", rdata);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL missing_rvalid: got rvalid=0, expected read data %h", exp_q[0]);
        void'(exp_q.pop_front());
      end
      check("led_out", 32'(led_out), 32'(m_led));
      check("sw_db", 32'(sw_db), 32'(m_db));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    addr    = a;
    io_read = 1'b1;
    tick();
    io_read = 1'b0;
    addr    = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr     = a;
    wdata    = d;
    io_write = 1'b1;
    tick();
    io_write = 1'b0;
    addr     = '0;
  endtask

  task automatic wait_db(input int bit_idx, output int n);
    n = 0;
    while (sw_db[bit_idx] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int op;
    logic [31:0] a;
    logic [7:0] offs [6];
    offs[0] = 8'h60; offs[1] = 8'h70; offs[2] = 8'h74;
    offs[3] = 8'h80; offs[4] = 8'h64; offs[5] = 8'h00;

    reset = 1'b1; io_read = 1'b0; io_write = 1'b0;
    addr = '0; wdata = '0; sw_in = '0;
    repeat (3) tick();
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b0;
    tick();

    // LED write then readback
    wr(32'hFFFFFC60, 32'hA5A5A5A5);
    check("led_direct", 32'(led_out), 32'h00A5A5A5);
    rd(32'hFFFFFC60);
    check("led_read", rdata, 32'h00A5A5A5);
    check("led_read_valid", 32'(rvalid), 32'd1);
    tick();
    check("rvalid_drop", 32'(rvalid), 32'd0);

    // Debounce accept of bit 3
    sw_in[3] = 1'b1;
    wait_db(3, n);
    check("db_latency", 32'(n - 1), 32'd17);
    rd(32'hFFFFFC74);
    check("chg_bit3", rdata, 32'h8);
    rd(32'hFFFFFC74);
    check("chg_cleared", rdata, 32'h0);

    // Glitch shorter than the debounce window
    sw_in[0] = 1'b1;
    repeat (10) tick();
    sw_in[0] = 1'b0;
    repeat (30) tick();
    check("glitch_db", 32'(sw_db[0]), 32'd0);
    rd(32'hFFFFFC74);
    check("glitch_chg", rdata, 32'h0);

    // CHG read lands on the same edge as the accept of bit 5
    sw_in[5] = 1'b1;
    repeat (17) tick();
    rd(32'hFFFFFC74);
    check("set_clear_first", rdata, 32'h0);
    check("set_clear_db", 32'(sw_db[5]), 32'd1);
    rd(32'hFFFFFC74);
    check("set_clear_second", rdata, 32'h20);

    // Timer wrap (reads 0 either way)
    wr(32'hFFFFFC80, 32'hFFFFFFFE);
    tick();
    tick();
    rd(32'hFFFFFC80);
    check("timer_wrap", rdata, 32'h0);

    // Reset mid-debounce, then re-accept from scratch
    sw_in[7] = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_sw_db", 32'(sw_db), 32'd0);
    reset = 1'b0;
    wait_db(7, n);
    check("reaccept_latency", 32'(n - 1), 32'd17);
    rd(32'hFFFFFC74);
    check("reaccept_chg", rdata, 32'hA8);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      op = int'($urandom_range(0, 9));
      a  = {22'h3FFFFF, 2'($urandom), offs[$urandom_range(0, 5)]};
      if ($urandom_range(0, 7) == 0) a = $urandom & 32'h7FFFFFFF;
      wdata    = $urandom;
      addr     = a;
      io_read  = (op <= 3) || (op == 6);
      io_write = (op == 4) || (op == 5) || (op == 6);
      if ($urandom_range(0, 19) == 0) sw_in[$urandom_range(0, SW - 1)] ^= 1'b1;
      tick();
    end
    io_read  = 1'b0;
    io_write = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_gpio_hub.md
# mmio_gpio_hub

Parametrised memory-mapped GPIO hub for the single-cycle MIPS CPU. It replaces the separate LED and switch I/O blocks with a single I/O slave that has configurable LED and switch widths. It adds per-bit switch debouncing, sticky change flags and registered read data with a valid strobe. It sits on the CPU's I/O port: the controller drives io_read/io_write, the ALU result drives addr, and the register file supplies the write data.

## Interface
Parameters:
- SW_WIDTH, 24: number of switch inputs, 1..32.
- LED_WIDTH, 24: number of LED outputs, 1..32.
- DB_CYCLES, 16: consecutive stable samples required to accept a switch change, ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  CPU clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- io_read  in  1  I/O read request from controller, single-cycle pulse.
- io_write  in  1  I/O write request from controller, single-cycle pulse.
- addr  in  32  byte address from ALU result.
- wdata  in  32  write data from register file.
- rdata  out  32  registered read data.
- rvalid  out  1  high for one cycle when rdata holds a completed read.
- sw_in  in  SW_WIDTH  raw asynchronous switch pins.
- led_out  out  LED_WIDTH  LED drive, registered.
- sw_db  out  SW_WIDTH  debounced switch state, for debug.

## Operation
- Region decode: an access is in the I/O region when addr[31:10] == 22'h3FFFFF. The register offset is addr[7:0]. Accesses outside the region are ignored entirely, and rvalid is not raised.
- Register map:
  - 0x60 LED: read/write. A write loads wdata[LED_WIDTH-1:0], and the upper bits are ignored. A read returns the LED value zero-extended.
  - 0x70 SW: read-only. Returns sw_db zero-extended. Writes are ignored.
  - 0x74 CHG: sticky per-bit change flags, zero-extended. A read returns the flags and clears them. Writes are ignored.
  - 0x80 TIMER: present only with the macro (see Configuration).
  - Any other offset: reads return 0, writes are ignored.
- Switch path, per bit:
  - Two-flop synchroniser s1→s2.
  - Counter cnt, width $clog2(DB_CYCLES+1).
  - If s2 == db: cnt ← 0.
  - If s2 != db and cnt == DB_CYCLES-1: db ← s2, cnt ← 0, chg ← 1.
  - Otherwise: cnt ← cnt+1.
  - DB_CYCLES=1 means any synchronised change is accepted on its first differing sample.
- Simultaneous events:
  - A CHG read in the same cycle as a new accept for bit i: bit i ends at 1, because set beats clear. The returned rdata shows the pre-edge flags.
  - If io_read and io_write are both high, the write is performed and no read occurs (rvalid stays 0).
- Reset values: led_out=0, rdata=0, rvalid=0, sw_db=0, s1=s2=0, all cnt=0, CHG=0, timer=0. Reset asserted mid-debounce aborts the count. After release, a switch held high is re-accepted from scratch.

## Timing
- Read latency is 1 cycle:
  - io_read sampled high at edge N → rdata valid and rvalid=1 after edge N.
  - rvalid drops after edge N+1 unless a new read is issued. rdata holds its value until the next read.
- Write: the register updates at the edge where io_write is sampled high. led_out reflects the new value immediately after that edge.
- Switch latency: a level change on sw_in that is stable before edge k appears on sw_db and sets CHG after edge k+1+DB_CYCLES. That breaks down as 2 synchroniser edges plus DB_CYCLES samples, with the first sample taken at edge k+2.
- Glitch rejection: a pulse shorter than DB_CYCLES samples after synchronisation never reaches sw_db.
- Back-to-back reads on consecutive cycles are supported. rvalid stays high, and rdata updates every cycle.

## Configuration
- IO_TIMER_EN defined:
  - A 32-bit free-running counter at offset 0x80 increments every clock and wraps from 0xFFFFFFFF to 0.
  - A write loads wdata; the increment resumes from the loaded value on the next edge.
  - A read returns the value before the edge.
- IO_TIMER_EN undefined: no counter logic is built. Offset 0x80 reads 0, and writes are ignored.

## Test plan
- Reset check: assert reset mid-run → led_out=0, rdata=0, rvalid=0, sw_db=0, CHG=0.
- LED write/readback:
  - Stimulus: LED_WIDTH=24, write 0xA5A5A5A5 to 0xFFFFFC60, then read it.
  - Response: led_out=0xA5A5A5 after the write edge; the read gives rdata=0x00A5A5A5 with rvalid for 1 cycle.
- Debounce accept:
  - Stimulus: DB_CYCLES=16, drive sw_in[3] 0→1 and hold.
  - Response: sw_db[3] rises exactly 17 edges later. A read of 0x74 returns 0x8; the next read of 0x74 returns 0.
- Glitch reject: DB_CYCLES=16, 10-cycle high pulse on sw_in[0] → sw_db and CHG stay 0.
- Set beats clear: a CHG read on the same edge as an accept of bit 5 → rdata excludes bit 5, and a following read returns 0x20.
- Timer (IO_TIMER_EN):
  - Stimulus: write 0xFFFFFFFE to 0x80, then wait 2 cycles and read.
  - Response: rdata=0x00000000 (wrapped). Without the macro, the same read returns 0.
